vga_sync_rx: RTL and testbench

//  VGA sink/monitor: samples the hs/vs/rgb stream produced by the display path and locks to its timing.

---
 rtl/vga_sync_rx.sv | 181 ++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA timing monitor: sync lock, pixel labels, violation flags, frame signature
module vga_sync_rx #(
    parameter int H_TOTAL       = 800,
    parameter int H_ACTIVE      = 640,
    parameter int V_TOTAL       = 525,
    parameter int V_ACTIVE      = 480,
    parameter int H_SYNC        = 96,
    parameter int V_SYNC        = 2,
    parameter int H_SYNC_OFFSET = 657,
    parameter int V_SYNC_OFFSET = 491,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [5:0]  i_rgb,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_de,
    output logic        o_locked,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_sig,
    output logic        o_sig_valid
);

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_HS     = 10'(H_SYNC_OFFSET);
    localparam logic [9:0] X_HS_END = 10'(H_SYNC_OFFSET + H_SYNC);
    localparam logic [9:0] Y_VS     = 10'(V_SYNC_OFFSET);
    localparam logic [9:0] Y_VS_END = 10'(V_SYNC_OFFSET + V_SYNC);
    localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
    localparam logic [3:0] GOOD_MAX = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

    state_t      state, state_nx;
    logic        h_ok, h_ok_nx;
    logic        clean, clean_nx;
    logic [3:0]  good_cnt, good_nx;

    // s_hs/s_vs hold the previous sample; x/y hold its labels
    logic        s_hs, s_vs;
    logic [9:0]  x, y;
    logic [15:0] sig_acc;
    logic        sig_arm;

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic        x_wrap;
    logic [9:0]  x_inc, y_inc, x_new, y_new;
    logic        checking, e_hp, e_hw, e_vp, e_vw, err, de_new;
    logic [1:0]  err_code;

    assign hs_fall = s_hs & ~i_hs;
    assign hs_rise = ~s_hs & i_hs;
    assign vs_fall = s_vs & ~i_vs;
    assign vs_rise = ~s_vs & i_vs;

    assign x_wrap = (x == X_LAST);
    assign x_inc  = x_wrap ? 10'd0 : x + 10'd1;
    assign y_inc  = x_wrap ? ((y == Y_LAST) ? 10'd0 : y + 10'd1) : y;
    assign x_new  = hs_fall ? X_HS : x_inc;
    assign y_new  = vs_fall ? Y_VS : y_inc;

    assign checking = (state != SEARCH);
    assign e_hp = hs_fall ? (x_inc != X_HS) : (x_inc == X_HS);
    assign e_hw = hs_rise & (x_new != X_HS_END);
    assign e_vp = vs_fall ? ((y_inc != Y_VS) | (x_new != 10'd0))
                          : ((y_inc == Y_VS) & (x_new == 10'd0));
    assign e_vw = vs_rise & ((y_new != Y_VS_END) | (x_new != 10'd0));
    assign err  = checking & (e_hp | e_hw | e_vp | e_vw);
    assign de_new = checking & (x_new < X_ACT) & (y_new < Y_ACT);

    always_comb begin
        err_code = 2'd3;
        if (e_hp)      err_code = 2'd0;
        else if (e_hw) err_code = 2'd1;
        else if (e_vp) err_code = 2'd2;
    end

    always_comb begin
        state_nx = state;
        h_ok_nx  = h_ok;
        clean_nx = clean;
        good_nx  = good_cnt;
        case (state)
            SEARCH: begin
                if (vs_fall && h_ok) begin
                    state_nx = MEASURE;
                    good_nx  = 4'd0;
                    clean_nx = 1'b1;
                end
                if (hs_fall) h_ok_nx = 1'b1;
            end
            MEASURE: begin
                // a frame counts only if no violation was seen since the previous vs fall
                if (err) begin
                    good_nx  = 4'd0;
                    clean_nx = 1'b0;
                end else if (vs_fall) begin
                    clean_nx = 1'b1;
                    if (clean) begin
                        good_nx = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == GOOD_MAX) state_nx = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err) begin
                    state_nx = SEARCH;
                    h_ok_nx  = 1'b0;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            h_ok     <= 1'b0;
            clean    <= 1'b0;
            good_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            h_ok     <= h_ok_nx;
            clean    <= clean_nx;
            good_cnt <= good_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_hs        <= 1'b0;
            s_vs        <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            sig_acc     <= 16'd0;
            sig_arm     <= 1'b0;
            o_x         <= 10'd0;
            o_y         <= 10'd0;
            o_de        <= 1'b0;
            o_locked    <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= 2'd0;
            o_sig       <= 16'd0;
            o_sig_valid <= 1'b0;
        end else begin
            s_hs        <= i_hs;
            s_vs        <= i_vs;
            x           <= x_new;
            y           <= y_new;
            o_x         <= checking ? x_new : 10'd0;
            o_y         <= checking ? y_new : 10'd0;
            o_de        <= de_new;
            o_locked    <= (state == LOCKED);
            o_err       <= err;
            o_err_code  <= err ? err_code : 2'd0;
            o_sig_valid <= 1'b0;
            // sig_arm is only set by a vs fall seen while locked, so a partial frame is never emitted
            if (state == LOCKED) begin
                if (err) begin
                    sig_arm <= 1'b0;
                end else if (vs_fall) begin
                    if (sig_arm) begin
                        o_sig       <= sig_acc;
                        o_sig_valid <= 1'b1;
                    end
                    sig_acc <= 16'd0;
                    sig_arm <= 1'b1;
                end else if (de_new) begin
                    sig_acc <= {sig_acc[14:0], sig_acc[15]} ^ {10'b0, i_rgb};
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - directed bench for vga_sync_rx on a reduced 40x20 timing
module tb_vga_sync_rx;

    localparam int HT = 40, HA = 16, HSW = 6, HO = 21;
    localparam int VT = 20, VA = 12, VSW = 2, VO = 15, LF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_hs = 1'b1, i_vs = 1'b1;
    logic [5:0]  i_rgb = 6'd0;
    logic [9:0]  o_x, o_y;
    logic        o_de, o_locked, o_err, o_sig_valid;
    logic [1:0]  o_err_code;
    logic [15:0] o_sig;

    vga_sync_rx #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
        .H_SYNC(HSW), .V_SYNC(VSW), .H_SYNC_OFFSET(HO), .V_SYNC_OFFSET(VO),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_rgb(i_rgb),
        .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_locked(o_locked), .o_err(o_err),
        .o_err_code(o_err_code), .o_sig(o_sig), .o_sig_valid(o_sig_valid)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // generator position of the sample currently on the inputs, plus fault knobs
    int gx = HT - 1, gy = VT - 1;
    int hs_high_line = -1, hs_long_line = -1, pix_mode = 0;
    bit vs_long = 0;

    task automatic drive_one(input bit r);
        int hw, vl;
        @(negedge clk);
        if (gx == HT - 1) begin
            gx = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
        rst  = r;
        hw   = (gy == hs_long_line) ? HSW + 1 : HSW;
        vl   = vs_long ? VSW + 1 : VSW;
        i_hs = !(gx >= HO && gx < HO + hw) || (gy == hs_high_line);
        i_vs = !(gy >= VO && gy < VO + vl);
        case (pix_mode)
            1: i_rgb = (gx == 0 && gy == 0) ? 6'd1 : 6'd0;
            2: i_rgb = (gx == HA - 1 && gy == VA - 1) ? 6'd1 : 6'd0;
            3: i_rgb = 6'((gx * 5 + gy * 3 + 1) % 64);
            default: i_rgb = 6'd0;
        endcase
    endtask

    task automatic run_cycles(input int n);
        repeat (n) drive_one(1'b0);
    endtask

    task automatic run_frames(input int n);
        run_cycles(n * HT * VT);
    endtask

    // reference model: lock progress tracked as anchor + count of clean frames
    bit          m_phs, m_pvs, m_hseen, m_anch, m_dirty, m_arm;
    int          m_clean;
    logic [5:0]  m_q[$];
    logic [15:0] m_sig;
    bit          hf, hr, vf, vr, chk, lk, e0, e1, e2, e3, x_err, x_de, x_sv;
    int          x_x, x_y, x_code;
    logic [41:0] got, want;
    int          samp = 0, cur;
    int          lock_idx = -1, err_cnt = 0, sv_cnt = 0;
    int          last_err_x = -1, last_err_y = -1, last_err_code = -1;
    bit          prev_err = 0;
    logic        locked_after_err = 1'bx;
    logic [15:0] last_sig = 16'hxxxx;

    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        int k;
        k = n % 16;
        return (v << k) | (v >> (16 - k));
    endfunction

    always @(posedge clk) begin
        #1;
        x_x = 0; x_y = 0; x_de = 0; x_err = 0; x_code = 0; x_sv = 0; lk = 0;
        if (rst) begin
            m_phs = 0; m_pvs = 0; m_hseen = 0; m_anch = 0; m_dirty = 0; m_arm = 0;
            m_clean = 0; m_sig = 16'd0; m_q.delete();
            samp = 0; lock_idx = -1; prev_err = 0;
        end else begin
            cur = samp; samp++;
            hf = m_phs && !i_hs; hr = !m_phs && i_hs;
            vf = m_pvs && !i_vs; vr = !m_pvs && i_vs;
            m_phs = i_hs; m_pvs = i_vs;
            chk = m_anch;
            lk  = m_anch && (m_clean >= LF);
            e0 = hf ? (gx != HO) : (gx == HO);
            e1 = hr && (gx != HO + HSW);
            e2 = vf ? (gy != VO || gx != 0) : (gy == VO && gx == 0);
            e3 = vr && (gy != VO + VSW || gx != 0);
            x_err  = chk && (e0 || e1 || e2 || e3);
            x_code = !x_err ? 0 : e0 ? 0 : e1 ? 1 : e2 ? 2 : 3;
            x_x  = chk ? gx : 0;
            x_y  = chk ? gy : 0;
            x_de = chk && gx < HA && gy < VA;
            if (lk) begin
                if (x_err) m_arm = 0;
                else if (vf) begin
                    if (m_arm) begin
                        m_sig = 16'd0;
                        foreach (m_q[i]) m_sig ^= rotl({10'b0, m_q[i]}, m_q.size() - 1 - i);
                        x_sv = 1;
                    end
                    m_q.delete();
                    m_arm = 1;
                end else if (x_de) m_q.push_back(i_rgb);
            end
            if (!m_anch) begin
                if (vf && m_hseen) begin
                    m_anch = 1; m_clean = 0; m_dirty = 0;
                end
                if (hf) m_hseen = 1;
            end else if (lk) begin
                if (x_err) begin
                    m_anch = 0; m_hseen = 0;
                end
            end else if (x_err) begin
                m_clean = 0; m_dirty = 1;
            end else if (vf) begin
                if (!m_dirty) m_clean++;
                m_dirty = 0;
            end
            if (o_locked === 1'b1 && lock_idx < 0) lock_idx = cur;
            if (prev_err) locked_after_err = o_locked;
            prev_err = (o_err === 1'b1);
            if (o_err === 1'b1) begin
                err_cnt++; last_err_x = int'(o_x); last_err_y = int'(o_y); last_err_code = int'(o_err_code);
            end
            if (o_sig_valid === 1'b1) begin
                sv_cnt++; last_sig = o_sig;
            end
        end
        got  = {o_x, o_y, o_de, o_locked, o_err, o_err_code, o_sig_valid, o_sig};
        want = {10'(x_x), 10'(x_y), x_de, lk, x_err, 2'(x_code), x_sv, m_sig};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL cycle s=%0d pos=(%0d,%0d): got %h want %h", samp, gx, gy, got, want);
        end
    end

    int sv_before;

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        check("reset_x", o_x, 0);
        check("reset_locked", o_locked, 0);
        check("reset_sig", {o_sig_valid, o_sig}, 0);

        // from reset: anchor at sample 600, lock output from sample 2201
        run_frames(5);
        check("lock_latency", lock_idx, 2201);
        check("no_err_phase1", err_cnt, 0);
        check("sig_count_zero", sv_cnt, 1);
        check("sig_zero", last_sig, 16'h0000);

        pix_mode = 1; run_frames(1);
        check("sig_pix00", last_sig, 16'h8000);
        check("sig_count_pix00", sv_cnt, 2);
        pix_mode = 2; run_frames(1);
        check("sig_pixlast", last_sig, 16'h0001);
        pix_mode = 3; run_frames(1);
        check("sig_count_pattern", sv_cnt, 4);

        // hs held high on line 3
        hs_high_line = 3; run_frames(1); hs_high_line = -1;
        check("hs_period_cnt", err_cnt, 1);
        check("hs_period_code", last_err_code, 0);
        check("hs_period_xy", {last_err_x, last_err_y}, {32'd21, 32'd3});
        check("unlock_next_clk", locked_after_err, 1'b0);
        run_frames(1);
        check("relock_wait", o_locked, 1'b0);
        run_frames(1);
        check("relocked", o_locked, 1'b1);
        run_frames(1);

        // one hs pulse one clock too long on line 5
        hs_long_line = 5; run_frames(1); hs_long_line = -1;
        check("hs_width_cnt", err_cnt, 2);
        check("hs_width_code", last_err_code, 1);
        check("hs_width_xy", {last_err_x, last_err_y}, {32'd28, 32'd5});
        check("hs_width_unlock", o_locked, 1'b0);
        run_frames(2);
        check("relocked2", o_locked, 1'b1);
        run_frames(1);

        // vs low for three lines
        vs_long = 1; run_frames(1); vs_long = 0;
        check("vs_width_cnt", err_cnt, 3);
        check("vs_width_code", last_err_code, 3);
        check("vs_width_xy", {last_err_x, last_err_y}, {32'd0, 32'd18});
        sv_before = sv_cnt;
        run_frames(1);
        check("no_sig_after_vs_err", sv_cnt, sv_before);

        // one-cycle reset while measuring, at position (5,2)
        run_cycles(85);
        drive_one(1'b1);
        @(posedge clk); #2;
        check("rst_xy", {o_x, o_y}, 0);
        check("rst_flags", {o_de, o_locked, o_err, o_err_code, o_sig_valid}, 0);
        check("rst_sig", o_sig, 0);
        run_cycles(HT * VT - 86);
        run_frames(2);
        check("relock_after_rst", lock_idx, 2115);
        run_frames(1);
        check("final_err_cnt", err_cnt, 3);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
